// File: rtl/timer_pkg.sv
// Shared types and constants for the tick timer controller.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_PERIOD = 1;
  localparam int WIDTH_DEF  = 16;

endpackage

// File: rtl/tick_timer_ctrl_prescaler.sv
// Modulo-PRESCALE up-counter; o_tick marks the last count of each prescale window.
module prescaler #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_timer_ctrl.sv
// Programmable tick timer: prescaler plus WIDTH-bit down-counter, one-shot or periodic.
// Optional sticky interrupt built only when TICK_TIMER_IRQ_EN is defined.
module tick_timer_ctrl
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int WIDTH    = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             irq,
  input  logic             irq_ack
);

  state_t           r_state;
  logic [WIDTH-1:0] r_period;
  logic             r_periodic;
  logic [WIDTH-1:0] r_count;
  logic             r_expire;

  logic [WIDTH-1:0] w_load_period;
  logic             w_load_ok;
  logic             w_run;
  logic             w_restart;
  logic             w_tick;
  logic             w_last;
  logic             w_clr;
  logic             w_expire_set;

  // A period written in the same cycle as a load is the one that gets loaded.
  assign w_load_period = cfg_we ? cfg_period : r_period;
  assign w_load_ok     = (w_load_period >= WIDTH'(MIN_PERIOD));
  assign w_run         = (r_state == RUN);
  assign w_restart     = start && w_load_ok;
  assign w_last        = (r_count == WIDTH'(1));
  assign w_clr         = w_run && (stop || w_restart);
  assign w_expire_set  = w_run && !stop && !w_restart && w_tick && w_last;

  prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .i_en   (w_run),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_period   <= '0;
      r_periodic <= 1'b0;
      r_count    <= '0;
      r_expire   <= 1'b0;
    end else begin
      r_expire <= w_expire_set;
      if (cfg_we) begin
        r_period   <= cfg_period;
        r_periodic <= cfg_periodic;
      end
      case (r_state)
        IDLE: begin
          if (w_restart) begin
            r_state <= RUN;
            r_count <= w_load_period;
          end
        end
        RUN: begin
          // stop beats start, start beats tick; count is held on stop.
          if (stop) begin
            r_state <= IDLE;
          end else if (w_restart) begin
            r_count <= w_load_period;
          end else if (w_tick) begin
            if (!w_last) begin
              r_count <= r_count - WIDTH'(1);
            end else if (r_periodic && w_load_ok) begin
              r_count <= w_load_period;
            end else begin
              r_count <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TICK_TIMER_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_expire_set) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_ack;

  assign w_unused_irq_ack = irq_ack;
  assign irq              = 1'b0;
`endif

  assign busy   = w_run;
  assign count  = r_count;
  assign expire = r_expire;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl: expected expiry edges are queued at start and matched on expire.
module tb_tick_timer_ctrl;

  localparam int PRESCALE = 4;
  localparam int WIDTH    = 16;
`ifdef TICK_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic             clk          = 1'b0;
  logic             reset_n      = 1'b0;
  logic             cfg_we       = 1'b0;
  logic [WIDTH-1:0] cfg_period   = '0;
  logic             cfg_periodic = 1'b0;
  logic             start        = 1'b0;
  logic             stop         = 1'b0;
  logic             irq_ack      = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             expire;
  logic             irq;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  tick_timer_ctrl #(
    .PRESCALE(PRESCALE),
    .WIDTH   (WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_period  (cfg_period),
    .cfg_periodic(cfg_periodic),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .count       (count),
    .expire      (expire),
    .irq         (irq),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge when read at a falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("expire_missed", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (expire) begin
        if (exp_q.size() == 0) begin
          check("expire_unexpected", cyc, -1);
        end else begin
          check("expire_edge", cyc, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic write_cfg(input int p, input logic per);
    cfg_we       = 1'b1;
    cfg_period   = WIDTH'(p);
    cfg_periodic = per;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(output int e);
    start = 1'b1;
    e     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int e;
  int f;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_expire", expire, 0);
    check("rst_irq", irq, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // One-shot, period 3
    write_cfg(3, 1'b0);
    pulse_start(e);
    exp_q.push_back(e + 12);
    check("os_busy_start", busy, 1);
    check("os_count_e0", count, 3);
    wait_until(e + 4);
    check("os_count_e4", count, 2);
    wait_until(e + 8);
    check("os_count_e8", count, 1);
    wait_until(e + 11);
    check("os_busy_e11", busy, 1);
    wait_until(e + 12);
    check("os_busy_e12", busy, 0);
    check("os_count_e12", count, 0);
    wait_until(e + 13);
    check("os_expire_e13", expire, 0);

    // Periodic, period 2
    write_cfg(2, 1'b1);
    pulse_start(e);
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 16);
    exp_q.push_back(e + 24);
    wait_until(e + 25);
    check("per_busy", busy, 1);
    check("per_count_reload", count, 2);
    pulse_stop();
    check("per_stop_busy", busy, 0);
    check("per_stop_count", count, 2);

    // Illegal period 0: start ignored
    write_cfg(0, 1'b0);
    pulse_start(e);
    check("p0_busy", busy, 0);
    check("p0_count_held", count, 2);
    repeat (12) @(negedge clk);
    check("p0_busy_later", busy, 0);

    // start and stop together while running
    write_cfg(3, 1'b0);
    pulse_start(e);
    wait_until(e + 5);
    check("ss_count_pre", count, 2);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_count_held", count, 2);
    repeat (10) @(negedge clk);
    check("ss_busy_later", busy, 0);
    pulse_start(f);
    exp_q.push_back(f + 12);
    check("ss_restart_busy", busy, 1);
    check("ss_restart_count", count, 3);
    wait_until(f + 13);
    check("ss_final_count", count, 0);

    // Period change mid-count in periodic mode
    write_cfg(2, 1'b1);
    pulse_start(e);
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 28);
    wait_until(e + 2);
    write_cfg(5, 1'b1);
    check("pc_count_old", count, 2);
    wait_until(e + 9);
    check("pc_count_new", count, 5);
    wait_until(e + 27);
    check("pc_count_e27", count, 1);
    wait_until(e + 29);
    pulse_stop();
    check("pc_stop_count", count, 5);
    check("pc_stop_busy", busy, 0);

    // Interrupt: set coincident with ack, then a lone ack
    write_cfg(1, 1'b0);
    pulse_start(e);
    exp_q.push_back(e + 4);
    wait_until(e + 3);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check("irq_set_wins", irq, IRQ_ON);
    check("irq_busy", busy, 0);
    @(negedge clk);
    check("irq_sticky", irq, IRQ_ON);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check("irq_acked", irq, 0);

    // Asynchronous reset mid-run
    write_cfg(2, 1'b1);
    pulse_start(e);
    wait_until(e + 3);
    check("ar_busy_pre", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_count", count, 0);
    check("ar_expire", expire, 0);
    check("ar_irq", irq, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_start(e);
    check("ar_period_cleared", busy, 0);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
